// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: sequencer state encoding and the Moore output decode shared by the lock sequencer
package pll_seq_pkg;
  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT} state_t;
  typedef struct packed {
    logic pll_rst;
    logic sys_rst;
    logic ready;
    logic fault;
  } outs_t;
  function automatic outs_t outs(input state_t s);
    return '{s == RESET_PLL, s != RUN, s == RUN, s == FAULT};
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer (clk, async active-high rst clears both flops, d async in, q synchronized out)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] r;
  always_ff @(posedge clk or posedge rst)
    if (rst) r <= '0;
    else r <= {r[0], d};
  assign q = r[1];
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL reset/lock sequencer (refclk, rst, pll_locked, relock_req in; pll_rst, sys_rst, ready, fault, retry_cnt, lost_lock_cnt out)
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic refclk,
  input  logic rst,
  input  logic pll_locked,
  input  logic relock_req,
  output logic pll_rst,
  output logic sys_rst,
  output logic ready,
  output logic fault,
  output logic [((MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1)-1:0] retry_cnt,
  output logic [7:0] lost_lock_cnt
);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int MAXC = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] RST_LD = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LD = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ST_LD = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRIES);
  state_t state;
  outs_t o;
  logic [CW-1:0] cnt;
  logic locked_s;
  sync_2ff u_sync (.clk(refclk), .rst(rst), .d(pll_locked), .q(locked_s));
  // Outputs are registered alongside the state so they always equal the decode of the current state.
  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      state <= RESET_PLL;
      o <= outs(RESET_PLL);
      cnt <= RST_LD;
      retry_cnt <= '0;
      lost_lock_cnt <= '0;
    end else
      case (state)
        RESET_PLL:
          if (cnt == '0) begin
            state <= WAIT_LOCK;
            o <= outs(WAIT_LOCK);
            cnt <= TO_LD;
          end else cnt <= cnt - 1'b1;
        WAIT_LOCK:
          if (locked_s) begin
            state <= STABLE;
            o <= outs(STABLE);
            cnt <= ST_LD;
          end else if (cnt != '0) cnt <= cnt - 1'b1;
          else if (retry_cnt == RMAX) begin
            state <= FAULT;
            o <= outs(FAULT);
          end else begin
            state <= RESET_PLL;
            o <= outs(RESET_PLL);
            cnt <= RST_LD;
            retry_cnt <= retry_cnt + 1'b1;
          end
        STABLE:
          if (!locked_s) begin
            state <= WAIT_LOCK;
            o <= outs(WAIT_LOCK);
            cnt <= TO_LD;
          end else if (cnt == '0) begin
            state <= RUN;
            o <= outs(RUN);
            retry_cnt <= '0;
          end else cnt <= cnt - 1'b1;
        RUN:
          if (!locked_s || relock_req) begin
            state <= RESET_PLL;
            o <= outs(RESET_PLL);
            cnt <= RST_LD;
            retry_cnt <= '0;
            if (!locked_s && lost_lock_cnt != 8'hff) lost_lock_cnt <= lost_lock_cnt + 8'd1;
          end
        FAULT:
          if (relock_req) begin
            state <= RESET_PLL;
            o <= outs(RESET_PLL);
            cnt <= RST_LD;
            retry_cnt <= '0;
          end
        default: begin
          state <= RESET_PLL;
          o <= outs(RESET_PLL);
          cnt <= RST_LD;
        end
      endcase
  assign {pll_rst, sys_rst, ready, fault} = o;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: randomized and directed checks of pll_lock_sequencer against a cycle-level phase model
module tb_pll_lock_sequencer;
  localparam int RP = 4, ST = 8, TO = 32, MR = 2;
  logic refclk = 0, rst = 1, pll_locked = 0, relock_req = 0;
  logic pll_rst, sys_rst, ready, fault;
  logic [1:0] retry_cnt;
  logic [7:0] lost_lock_cnt;
  int total = 0, bad = 0;
  int ph = 0, t = 0, tries = 0, lost = 0, n;
  bit m1 = 0, m2 = 0, ls;
  always #5 refclk = ~refclk;
  pll_lock_sequencer #(
    .RST_PULSE_CYCLES(RP), .LOCK_STABLE_CYCLES(ST), .LOCK_TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .relock_req(relock_req),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fault(fault),
    .retry_cnt(retry_cnt), .lost_lock_cnt(lost_lock_cnt)
  );
  // phase: 0 pulsing PLL reset, 1 waiting for lock, 2 proving stability, 3 running, 4 faulted; t counts cycles spent in the phase
  always @(posedge refclk or posedge rst)
    if (rst) begin
      ph = 0; t = 0; tries = 0; lost = 0; m1 = 0; m2 = 0;
    end else begin
      ls = m2; m2 = m1; m1 = pll_locked;
      case (ph)
        0: begin t++; if (t == RP) begin ph = 1; t = 0; end end
        1: if (ls) begin ph = 2; t = 0; end
           else begin
             t++;
             if (t == TO) begin
               t = 0;
               if (tries < MR) begin tries++; ph = 0; end else ph = 4;
             end
           end
        2: if (!ls) begin ph = 1; t = 0; end
           else begin t++; if (t == ST) begin ph = 3; tries = 0; end end
        3: if (!ls || relock_req) begin
             if (!ls && lost < 255) lost++;
             ph = 0; t = 0; tries = 0;
           end
        default: if (relock_req) begin ph = 0; t = 0; tries = 0; end
      endcase
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_all();
    chk("pll_rst", 32'(pll_rst), 32'(ph == 0));
    chk("sys_rst", 32'(sys_rst), 32'(ph != 3));
    chk("ready", 32'(ready), 32'(ph == 3));
    chk("fault", 32'(fault), 32'(ph == 4));
    chk("retry_cnt", 32'(retry_cnt), 32'(tries));
    chk("lost_lock_cnt", 32'(lost_lock_cnt), 32'(lost));
  endtask
  task automatic step(input int k);
    repeat (k) begin
      @(negedge refclk);
      chk_all();
    end
  endtask
  task automatic pulse_relock();
    relock_req = 1;
    step(1);
    relock_req = 0;
  endtask
  initial begin
    step(3);
    rst = 0;
    step(10);
    pll_locked = 1;
    n = 0;
    while (!ready && n < 100) begin
      step(1);
      n++;
    end
    chk("lock_to_ready_latency", 32'(n), 32'(ST + 3));
    step(5);
    pll_locked = 0;
    step(2);
    pll_locked = 1;
    step(40);
    chk("lost_after_drop", 32'(lost_lock_cnt), 32'd1);
    pulse_relock();
    step(10);
    pll_locked = 0;
    step(1);
    pll_locked = 1;
    step(30);
    pll_locked = 0;
    step(3 + 3 * (RP + TO) + 10);
    step(20);
    chk("fault_held", 32'(fault), 32'd1);
    chk("fault_retry", 32'(retry_cnt), 32'(MR));
    pulse_relock();
    pll_locked = 1;
    step(7);
    pulse_relock();
    step(25);
    pulse_relock();
    step(9);
    rst = 1;
    #1;
    chk("arst_pll_rst", 32'(pll_rst), 32'd1);
    chk("arst_sys_rst", 32'(sys_rst), 32'd1);
    chk("arst_ready", 32'(ready), 32'd0);
    chk("arst_fault", 32'(fault), 32'd0);
    chk("arst_retry", 32'(retry_cnt), 32'd0);
    chk("arst_lost", 32'(lost_lock_cnt), 32'd0);
    step(2);
    pll_locked = 0;
    rst = 0;
    step(33);
    pll_locked = 1;
    step(3);
    chk("lock_wins_retry", 32'(retry_cnt), 32'd0);
    chk("lock_wins_pll_rst", 32'(pll_rst), 32'd0);
    step(20);
    repeat (2000) begin
      if ($urandom_range(0, 39) == 0) pll_locked = ~pll_locked;
      relock_req = ($urandom_range(0, 29) == 0);
      step(1);
    end
    relock_req = 0;
    pll_locked = 1;
    step(30);
    repeat (258) begin
      pll_locked = 0;
      step(3);
      pll_locked = 1;
      step(22);
    end
    chk("lost_saturated", 32'(lost_lock_cnt), 32'd255);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 16, PLL reset pulse length in refclk cycles (>=1).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, consecutive synchronized-locked cycles required before release (>=1).
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536, maximum wait for lock per attempt (>LOCK_STABLE_CYCLES).
REQ-004 SHALL have parameter MAX_RETRIES, default 3, PLL reset re-attempts after a timeout before fault (>=0).
REQ-005 SHALL have port refclk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port pll_locked, input, 1, PLL locked indication, asynchronous to refclk.
REQ-008 SHALL have port relock_req, input, 1, single-cycle request to restart the PLL.
REQ-009 SHALL have port pll_rst, output, 1, reset driven to the PLL rst input.
REQ-010 SHALL have port sys_rst, output, 1, active-high reset for downstream ADC/UART logic.
REQ-011 SHALL have port ready, output, 1, PLL locked and stable.
REQ-012 SHALL have port fault, output, 1, retries exhausted.
REQ-013 SHALL have port retry_cnt, output, clog2(MAX_RETRIES+1), retries used in the current acquisition.
REQ-014 SHALL have port lost_lock_cnt, output, 8, saturating count of lock losses while in RUN.

Function
REQ-015 SHALL synchronize pll_locked through two flops to locked_s before any use.
REQ-016 SHALL implement the states RESET_PLL, WAIT_LOCK, STABLE, RUN and FAULT, with one shared down-counter sized for LOCK_TIMEOUT_CYCLES.
REQ-017 RESET_PLL: pll_rst=1 for exactly RST_PULSE_CYCLES cycles, then WAIT_LOCK with the timeout counter loaded.
REQ-018 WAIT_LOCK: locked_s=1 -> STABLE; timeout expiry with retry_cnt<MAX_RETRIES -> retry_cnt+1, RESET_PLL; with retry_cnt=MAX_RETRIES -> FAULT.
REQ-019 WAIT_LOCK: when locked_s rises in the cycle the timeout expires, lock SHALL win.
REQ-020 STABLE: any locked_s=0 cycle -> WAIT_LOCK with the timeout reloaded and no pll_rst pulse; LOCK_STABLE_CYCLES consecutive high cycles -> RUN, clearing retry_cnt.
REQ-021 RUN: locked_s=0 or relock_req -> RESET_PLL with retry_cnt=0; lost_lock_cnt increments (saturating at 255) only on locked_s=0.
REQ-022 FAULT: pll_rst=0, fault=1; the state is left only by relock_req (-> RESET_PLL, retry_cnt=0) or rst.
REQ-023 relock_req SHALL be ignored in RESET_PLL, WAIT_LOCK and STABLE.
REQ-024 All outputs SHALL be registered Moore decodes of state: sys_rst=1 and ready=0 in every state except RUN, where sys_rst=0 and ready=1.
REQ-025 With pll_locked steady high, ready SHALL rise exactly LOCK_STABLE_CYCLES+3 cycles after pll_locked rises during WAIT_LOCK.

Reset
REQ-026 While rst=1: state=RESET_PLL, counter loaded, pll_rst=1, sys_rst=1, ready=0, fault=0, retry_cnt=0, lost_lock_cnt=0, synchronizer flops=0.
REQ-027 Assertion of rst mid-operation SHALL force these values immediately (asynchronously); after deassertion a full RST_PULSE_CYCLES pulse SHALL follow.

Structure
REQ-028 The state enum and its encoding SHALL live in shared package pll_seq_pkg.
REQ-029 The two-flop synchronizer SHALL be a sub-module named sync_2ff.

Verification (RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2)
REQ-030 rst released and pll_locked rising 10 cycles later -> pll_rst high for 4 cycles; ready=1 and sys_rst=0 exactly 11 cycles after pll_locked rises.
REQ-031 pll_locked held at 0 -> three 4-cycle pll_rst pulses separated by 32-cycle waits, then fault=1 with retry_cnt=2 held indefinitely.
REQ-032 pll_locked low for 1 cycle after 5 stable cycles -> no pll_rst pulse; ready delayed by the restarted 8-cycle stability count.
REQ-033 pll_locked falls in RUN -> sys_rst=1 and pll_rst=1 within 3 cycles; 4-cycle pulse; lost_lock_cnt=1; relock proceeds normally.
REQ-034 In FAULT, relock_req pulse -> fault=0, retry_cnt=0, 4-cycle pll_rst pulse; the same pulse in STABLE -> no effect.
REQ-035 rst asserted mid-STABLE -> all outputs take their reset values in the same cycle, without waiting for a refclk edge.
